nor_self_test_ctrl: RTL and testbench

//   Sequencer that exercises a 2-input NOR gate (a,b -> c) in hardware. On start it

---
 rtl/nor_self_test_ctrl_pkg.sv | 9 +
 rtl/nor_self_test_ctrl_if.sv | 15 +
 rtl/nor_self_test_ctrl_settle_timer.sv | 18 +
 rtl/nor_self_test_ctrl.sv | 80 ++++++++
 tb/tb_nor_self_test_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/nor_self_test_ctrl_pkg.sv
// nor_ctrl_pkg: shared state encoding, vector count and expected-value helper
// for the NOR gate self-test controller.
package nor_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;
    localparam int NUM_VEC = 4;
    function automatic logic exp_nor(input logic [1:0] vec);
        return ~(vec[1] | vec[0]);
    endfunction
endpackage

// File: rtl/nor_self_test_ctrl_if.sv
// nor_self_test_ctrl_if: control/result bundle plus the NOR-gate pins driven and observed by the controller.
interface nor_self_test_ctrl_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic       fail_valid;
    logic [1:0] fail_vec;
    modport master (output start, c, input a, b, busy, done, pass, err_count, fail_valid, fail_vec);
    modport slave  (input start, c, output a, b, busy, done, pass, err_count, fail_valid, fail_vec);
endinterface

// File: rtl/nor_self_test_ctrl_settle_timer.sv
// nor_settle_timer: loadable 4-bit down-counter; zero flag marks the end of the settle window.
module nor_settle_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic       zero
);
    logic [3:0] cnt;
    always_ff @(posedge clk)
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 4'd1;
    assign zero = cnt == '0;
endmodule

// File: rtl/nor_self_test_ctrl.sv
// nor_self_test_ctrl: built-in self-test sequencer for a 2-input NOR gate.
// Optional NOR_CTRL_ABORT_EN: end the run at the first mismatching vector.
module nor_self_test_ctrl
    import nor_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    nor_self_test_ctrl_if.slave bus
);
    // Timer holds SETTLE_CYCLES-1 so its zero flag is seen on the final settle cycle.
    localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES == 0 ? 0 : SETTLE_CYCLES - 1);
    state_t     state, state_nxt;
    logic [1:0] vec;
    logic       zero, mism, last, stop;
    assign mism = bus.c != exp_nor(vec);
    assign last = vec == 2'(NUM_VEC - 1);
`ifdef NOR_CTRL_ABORT_EN
    assign stop = last | mism;
`else
    assign stop = last;
`endif
    nor_settle_timer u_timer (
        .clk(clk),
        .rst(rst),
        .load(state == APPLY),
        .load_val(LOAD_VAL),
        .zero(zero)
    );
    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? APPLY : IDLE;
            APPLY:   state_nxt = SETTLE_CYCLES == 0 ? CHECK : SETTLE;
            SETTLE:  state_nxt = zero ? CHECK : SETTLE;
            CHECK:   state_nxt = stop ? DONE : APPLY;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        bus.busy = state != IDLE;
        bus.done = state == DONE;
    end
    // a,b are loaded on the edge into APPLY so the vector is visible during APPLY.
    always_ff @(posedge clk) begin
        if (rst) begin
            {bus.a, bus.b} <= '0;
            vec            <= '0;
            bus.pass       <= 1'b0;
            bus.err_count  <= '0;
            bus.fail_valid <= 1'b0;
            bus.fail_vec   <= '0;
        end else if (state == IDLE && bus.start) begin
            {bus.a, bus.b} <= '0;
            vec            <= '0;
            bus.pass       <= 1'b0;
            bus.err_count  <= '0;
            bus.fail_valid <= 1'b0;
            bus.fail_vec   <= '0;
        end else if (state == CHECK) begin
            if (mism) begin
                bus.err_count <= bus.err_count + 3'd1;
                if (!bus.fail_valid) begin
                    bus.fail_valid <= 1'b1;
                    bus.fail_vec   <= vec;
                end
            end
            if (stop)
                bus.pass <= !mism && bus.err_count == '0;
            else begin
                vec            <= vec + 2'd1;
                {bus.a, bus.b} <= vec + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_nor_self_test_ctrl.sv
// tb_nor_self_test_ctrl: runs SETTLE_CYCLES=2 and =0 controllers side by side against a
// NOR gate with selectable faults, checking against a run-level model and a directed table.
module tb_nor_self_test_ctrl;
    logic clk = 0, rst = 1, start = 0;
    int   fmode = 0;
    int   checks = 0, failures = 0;
    always #5 clk = ~clk;

    nor_self_test_ctrl_if bus2();
    nor_self_test_ctrl_if bus0();

    // fault modes: 0 good gate, 1 stuck-0, 2 stuck-1, 3 inverted output
    function automatic logic gate(input int mode, input logic [1:0] v);
        return mode == 0 ? logic'(v == 2'd0) : mode == 1 ? 1'b0 : mode == 2 ? 1'b1 : logic'(v != 2'd0);
    endfunction

    assign bus2.start = start;
    assign bus0.start = start;
    assign bus2.c = gate(fmode, {bus2.a, bus2.b});
    assign bus0.c = gate(fmode, {bus0.a, bus0.b});

    nor_self_test_ctrl #(.SETTLE_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
    nor_self_test_ctrl #(.SETTLE_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));

    logic [10:0] o2, o0;
    logic [6:0]  r2, r0;
    assign r2 = {bus2.pass, bus2.err_count, bus2.fail_valid, bus2.fail_vec};
    assign r0 = {bus0.pass, bus0.err_count, bus0.fail_valid, bus0.fail_vec};
    assign o2 = {bus2.a, bus2.b, bus2.busy, bus2.done, r2};
    assign o0 = {bus0.a, bus0.b, bus0.busy, bus0.done, r0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Run-level model: which vectors get applied, how many mismatch, first failing vector.
    function automatic void model(input int mode, output int n, output logic [6:0] r);
        int e = 0;
        logic fv = 0;
        logic [1:0] fvec = 0;
        bit stop = 0;
        n = 0;
        for (int v = 0; v < 4; v++)
            if (!stop) begin
                n++;
                if (gate(mode, 2'(v)) != (v == 0)) begin
                    e++;
                    if (!fv) begin
                        fv = 1;
                        fvec = 2'(v);
                    end
`ifdef NOR_CTRL_ABORT_EN
                    stop = 1;
`endif
                end
            end
        r = {e == 0, 3'(e), fv, fvec};
    endfunction

    task automatic do_run(input int mode, output logic [6:0] res, output int dcyc);
        int n, d2, d0, got2 = -1, got0 = -1, nd2 = 0, nd0 = 0;
        logic [6:0] er;
        bit bab2 = 0, bab0 = 0, bb2 = 0, bb0 = 0;
        model(mode, n, er);
        d2 = n * 4 + 1;
        d0 = n * 2 + 1;
        fmode = mode;
        start = 1;
        tick();
        start = 0;
        for (int t = 1; t <= d2 + 2; t++) begin
            if (bus2.done) begin nd2++; got2 = t; end
            if (bus0.done) begin nd0++; got0 = t; end
            if (bus2.busy != (t <= d2)) bb2 = 1;
            if (bus0.busy != (t <= d0)) bb0 = 1;
            for (int k = 0; k < n; k++) begin
                if (t == 1 + 4 * k && {bus2.a, bus2.b} != 2'(k)) bab2 = 1;
                if (t == 1 + 2 * k && {bus0.a, bus0.b} != 2'(k)) bab0 = 1;
            end
            if (int'({bus2.a, bus2.b}) >= n) bab2 = 1;
            if (int'({bus0.a, bus0.b}) >= n) bab0 = 1;
            tick();
        end
        chk("ab_seq_s2", bab2, 0);
        chk("ab_seq_s0", bab0, 0);
        chk("busy_s2", bb2, 0);
        chk("busy_s0", bb0, 0);
        chk("done_count_s2", nd2, 1);
        chk("done_count_s0", nd0, 1);
        chk("done_cycle_s2", got2, d2);
        chk("done_cycle_s0", got0, d0);
        chk("results_s2", r2, er);
        chk("results_s0", r0, er);
        chk("hold_ab_s2", {bus2.a, bus2.b}, n - 1);
        chk("hold_ab_s0", {bus0.a, bus0.b}, n - 1);
        res = r2;
        dcyc = got2;
    endtask

    typedef struct {
        int         mode;
        logic [6:0] res;
        int         done;
    } vec_t;

    initial begin
        vec_t tbl[4];
        logic [6:0] r, er;
        int d, n, p20, p21;
        int dq2[$], dq0[$];
`ifdef NOR_CTRL_ABORT_EN
        tbl[0] = '{0, 7'b1_000_0_00, 17};
        tbl[1] = '{1, 7'b0_001_1_00, 5};
        tbl[2] = '{2, 7'b0_001_1_01, 9};
        tbl[3] = '{3, 7'b0_001_1_00, 5};
`else
        tbl[0] = '{0, 7'b1_000_0_00, 17};
        tbl[1] = '{1, 7'b0_001_1_00, 17};
        tbl[2] = '{2, 7'b0_011_1_01, 17};
        tbl[3] = '{3, 7'b0_100_1_00, 17};
`endif
        repeat (3) tick();
        chk("reset_s2", o2, 0);
        chk("reset_s0", o0, 0);
        rst = 0;
        tick();
        foreach (tbl[i]) begin
            do_run(tbl[i].mode, r, d);
            chk("tbl_results", r, tbl[i].res);
            chk("tbl_done", d, tbl[i].done);
            tick();
        end
        repeat (12) begin
            do_run($urandom_range(0, 3), r, d);
            repeat ($urandom_range(0, 3)) tick();
        end
        // start during a run and on the DONE cycle is ignored; later start clears results
        fmode = 0;
        p20 = -1;
        p21 = -1;
        for (int t = 0; t <= 40; t++) begin
            start = (t == 0 || t == 6 || t == 17 || t == 20);
            tick();
            if (bus2.done) dq2.push_back(t + 1);
            if (bus0.done) dq0.push_back(t + 1);
            if (t + 1 == 20) p20 = bus2.pass;
            if (t + 1 == 21) p21 = bus2.pass;
        end
        start = 0;
        chk("dup_start_n_s2", dq2.size(), 2);
        chk("dup_start_d0_s2", dq2.size() > 0 ? dq2[0] : -1, 17);
        chk("dup_start_d1_s2", dq2.size() > 1 ? dq2[1] : -1, 37);
        chk("dup_start_n_s0", dq0.size(), 2);
        chk("dup_start_d0_s0", dq0.size() > 0 ? dq0[0] : -1, 9);
        chk("dup_start_d1_s0", dq0.size() > 1 ? dq0[1] : -1, 26);
        chk("pass_before_restart", p20, 1);
        chk("pass_cleared_on_restart", p21, 0);
        tick();
        // reset mid-run discards the run; a fresh start afterwards completes normally
        fmode = 2;
        dq2 = {};
        dq0 = {};
        model(2, n, er);
        for (int t = 0; t <= 30; t++) begin
            start = (t == 0 || t == 10);
            rst = (t == 7);
            tick();
            if (t + 1 == 8) begin
                chk("midrun_reset_s2", o2, 0);
                chk("midrun_reset_s0", o0, 0);
            end
            if (t + 1 >= 10 && bus2.done) dq2.push_back(t + 1);
            if (t + 1 >= 10 && bus0.done) dq0.push_back(t + 1);
        end
        start = 0;
        rst = 0;
        chk("post_reset_n_s2", dq2.size(), 1);
        chk("post_reset_done_s2", dq2.size() > 0 ? dq2[0] : -1, 10 + n * 4 + 1);
        chk("post_reset_n_s0", dq0.size(), 1);
        chk("post_reset_done_s0", dq0.size() > 0 ? dq0[0] : -1, 10 + n * 2 + 1);
        chk("post_reset_results_s2", r2, er);
        chk("post_reset_results_s0", r0, er);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
